// File: rtl/csa_pkg.sv
// Level and row bookkeeping for the carry-save reduction tree.
// Each level turns n rows into 2*floor(n/3) + (n mod 3) rows; the tree stops at 2 rows.
package csa_pkg;
   localparam int MAX_NOPS = 16;
   localparam int MAX_LVLS = 8;

   // Row count seen at the input of every level; index 0 is the operand count.
   typedef int row_tab_t [0:MAX_LVLS];

   function automatic int csa_next(input int n);
      return (n > 2) ? 2 * (n / 3) + (n % 3) : n;
   endfunction

   function automatic int csa_rows(input int n, input int lvl);
      int r;
      r = n;
      for (int i = 0; i < MAX_LVLS; i++) begin
         if (i < lvl) r = csa_next(r);
      end
      return r;
   endfunction

   function automatic int csa_levels(input int n);
      int l;
      l = 0;
      for (int i = 0; i < MAX_LVLS; i++) begin
         if (csa_rows(n, i) > 2) l = l + 1;
      end
      return l;
   endfunction

   function automatic row_tab_t csa_row_tab(input int n);
      row_tab_t t;
      for (int i = 0; i <= MAX_LVLS; i++) t[i] = csa_rows(n, i);
      return t;
   endfunction
endpackage

// File: rtl/csa_tree_pipe_if.sv
// Operand-bundle / sum-carry handshake bundle of csa_tree_pipe.
// out_result is present only when CSA_FINAL_ADD_EN is defined.
interface csa_tree_pipe_if #(
   parameter int WIDTH = 8,
   parameter int NOPS  = 6
);
   localparam int OW = WIDTH + $clog2(NOPS);

   logic                  in_valid;
   logic                  in_ready;
   logic [NOPS*WIDTH-1:0] in_ops;
   logic                  out_valid;
   logic                  out_ready;
   logic [OW-1:0]         out_sum;
   logic [OW-1:0]         out_carry;
`ifdef CSA_FINAL_ADD_EN
   logic [OW-1:0]         out_result;
`endif

   modport slave (
      input  in_valid, in_ops, out_ready,
      output in_ready, out_valid, out_sum, out_carry
`ifdef CSA_FINAL_ADD_EN
      , output out_result
`endif
   );

   modport master (
      output in_valid, in_ops, out_ready,
      input  in_ready, out_valid, out_sum, out_carry
`ifdef CSA_FINAL_ADD_EN
      , input out_result
`endif
   );
endinterface

// File: rtl/csa_row.sv
// One row of 3:2 compressor cells over a W-bit slice; carry returned weight-aligned.
// Purely combinational, no handshake.
module csa_row #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] s,
   output logic [W-1:0] cy
);
   logic [W-2:0] maj;

   // three_to_two_comp cells; the majority of the top bit would land outside W and is never formed.
   for (genvar i = 0; i < W; i++) begin : g_cell
      assign s[i] = a[i] ^ b[i] ^ c[i];
      if (i < W - 1) begin : g_maj
         assign maj[i] = (a[i] ^ b[i]) ? c[i] : a[i];
      end
   end

   assign cy = {maj, 1'b0};
endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save tree: NOPS unsigned WIDTH-bit operands -> sum/carry pair (CSA_FINAL_ADD_EN adds out_result).
// Latency LVLS cycles, LVLS+1 when CSA_FINAL_ADD_EN adds the final carry-propagate stage.
// Backpressure: one global stall, in_ready = !out_valid | out_ready; all stages hold while stalled.
module csa_tree_pipe
   import csa_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NOPS  = 6
) (
   input logic            clk,
   input logic            rst,
   csa_tree_pipe_if.slave bus
);
   localparam int OW   = WIDTH + $clog2(NOPS);
   localparam int LVLS = csa_levels(NOPS);
`ifdef CSA_FINAL_ADD_EN
   localparam int NST  = LVLS + 1;
`else
   localparam int NST  = LVLS;
`endif

   typedef logic [OW-1:0] row_t;

   if (NOPS < 3 || NOPS > MAX_NOPS || WIDTH < 1) begin : g_bad_cfg
      $error("csa_tree_pipe: NOPS must be 3..16 and WIDTH at least 1");
   end

   logic           en;
   logic [NST-1:0] vld_q;
   logic [NST-1:0] vld_d;
   row_t           in_rows [NOPS];
   row_t           lvl_d   [1:LVLS][MAX_NOPS];
   row_t           lvl_q   [1:LVLS][MAX_NOPS];

   assign en = !vld_q[NST-1] || bus.out_ready;

   for (genvar k = 0; k < NOPS; k++) begin : g_in
      assign in_rows[k] = {{(OW - WIDTH){1'b0}}, bus.in_ops[k*WIDTH +: WIDTH]};
   end

   for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
      localparam int NI = csa_rows(NOPS, l - 1);
      localparam int NO = csa_rows(NOPS, l);
      localparam int NG = NI / 3;

      row_t src [NI];

      for (genvar r = 0; r < NI; r++) begin : g_src
         if (l == 1) begin : g_first
            assign src[r] = in_rows[r];
         end else begin : g_prev
            assign src[r] = lvl_q[l-1][r];
         end
      end

      for (genvar g = 0; g < NG; g++) begin : g_csa
         csa_row #(.W(OW)) u_row (
            .a  (src[3*g]),
            .b  (src[3*g+1]),
            .c  (src[3*g+2]),
            .s  (lvl_d[l][2*g]),
            .cy (lvl_d[l][2*g+1])
         );
      end

      // Rows left over after grouping by three ride through this level untouched.
      for (genvar p = 0; p < NI - 3*NG; p++) begin : g_pass
         assign lvl_d[l][2*NG+p] = src[3*NG+p];
      end

      for (genvar r = NO; r < MAX_NOPS; r++) begin : g_zero
         assign lvl_d[l][r] = '0;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            lvl_q[l] <= '{default: '0};
         end else if (en) begin
            lvl_q[l] <= lvl_d[l];
         end
      end
   end

   // Valid shifts one stage per enabled cycle; bit NST-1 is out_valid.
   always_comb begin
      vld_d = vld_q;
      if (en) vld_d = NST'({vld_q, bus.in_valid});
   end

   always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

`ifdef CSA_FINAL_ADD_EN
   row_t sum_q, sum_d;
   row_t car_q, car_d;
   row_t res_q, res_d;

   always_comb begin
      sum_d = sum_q;
      car_d = car_q;
      res_d = res_q;
      if (en) begin
         sum_d = lvl_q[LVLS][0];
         car_d = lvl_q[LVLS][1];
         res_d = lvl_q[LVLS][0] + lvl_q[LVLS][1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
         car_q <= '0;
         res_q <= '0;
      end else begin
         sum_q <= sum_d;
         car_q <= car_d;
         res_q <= res_d;
      end
   end

   assign bus.out_sum    = sum_q;
   assign bus.out_carry  = car_q;
   assign bus.out_result = res_q;
`else
   assign bus.out_sum    = lvl_q[LVLS][0];
   assign bus.out_carry  = lvl_q[LVLS][1];
`endif

   assign bus.out_valid = vld_q[NST-1];
   assign bus.in_ready  = en;
endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: NOPS=3/6/16 instances in lockstep, directed cases on NOPS=6, random streams on all.
`timescale 1ns/1ps
module tb_csa_tree_pipe;
   localparam int W  = 8;
   localparam int ND = 3;

   logic clk;
   logic rst;

   csa_tree_pipe_if #(.WIDTH(W), .NOPS(3))  if3  ();
   csa_tree_pipe_if #(.WIDTH(W), .NOPS(6))  if6  ();
   csa_tree_pipe_if #(.WIDTH(W), .NOPS(16)) if16 ();

   csa_tree_pipe #(.WIDTH(W), .NOPS(3))  dut3  (.clk(clk), .rst(rst), .bus(if3));
   csa_tree_pipe #(.WIDTH(W), .NOPS(6))  dut6  (.clk(clk), .rst(rst), .bus(if6));
   csa_tree_pipe #(.WIDTH(W), .NOPS(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0]    ops [16];
   logic            in_vld;
   logic            out_rdy;
   int              checks;
   int              failures;
   int              cyc;
   bit              lat_chk;
   longint unsigned sb_val [ND][$];
   int              sb_cyc [ND][$];
   bit              o_irdy [ND];
   bit              o_ovld [ND];
   longint unsigned o_sum  [ND];
   longint unsigned o_car  [ND];
`ifdef CSA_FINAL_ADD_EN
   longint unsigned o_res  [ND];
`endif
   bit              hold   [ND];
   longint unsigned h_sum  [ND];
   longint unsigned h_car  [ND];
   longint unsigned emits6 [$];
   int              emit_cyc6 [$];

   function automatic int nops_of(input int d);
      return (d == 0) ? 3 : (d == 1) ? 6 : 16;
   endfunction

   function automatic int ow_of(input int d);
      return (d == 0) ? 10 : (d == 1) ? 11 : 12;
   endfunction

   function automatic int lat_of(input int d);
      int l;
      l = (d == 0) ? 1 : (d == 1) ? 3 : 6;
`ifdef CSA_FINAL_ADD_EN
      l = l + 1;
`endif
      return l;
   endfunction

   function automatic longint unsigned exp_sum(input int d);
      longint unsigned s;
      s = 0;
      for (int k = 0; k < nops_of(d); k++) s = s + 64'(ops[k]);
      return s;
   endfunction

   task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic rand_ops();
      for (int k = 0; k < 16; k++)
         ops[k] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
   endtask

   task automatic drive();
      if3.in_valid  = in_vld;
      if6.in_valid  = in_vld;
      if16.in_valid = in_vld;
      if3.out_ready  = out_rdy;
      if6.out_ready  = out_rdy;
      if16.out_ready = out_rdy;
      for (int k = 0; k < 3; k++)  if3.in_ops[k*W +: W]  = ops[k];
      for (int k = 0; k < 6; k++)  if6.in_ops[k*W +: W]  = ops[k];
      for (int k = 0; k < 16; k++) if16.in_ops[k*W +: W] = ops[k];
   endtask

   task automatic sample();
      o_irdy[0] = if3.in_ready;  o_ovld[0] = if3.out_valid;
      o_irdy[1] = if6.in_ready;  o_ovld[1] = if6.out_valid;
      o_irdy[2] = if16.in_ready; o_ovld[2] = if16.out_valid;
      o_sum[0] = 64'(if3.out_sum);  o_car[0] = 64'(if3.out_carry);
      o_sum[1] = 64'(if6.out_sum);  o_car[1] = 64'(if6.out_carry);
      o_sum[2] = 64'(if16.out_sum); o_car[2] = 64'(if16.out_carry);
`ifdef CSA_FINAL_ADD_EN
      o_res[0] = 64'(if3.out_result);
      o_res[1] = 64'(if6.out_result);
      o_res[2] = 64'(if16.out_result);
`endif
   endtask

   // One clock: apply inputs, judge the handshake just before the edge, then advance.
   task automatic cycle();
      longint unsigned mask;
      longint unsigned ev;
      int              ec;
      drive();
      @(negedge clk);
      sample();
      for (int d = 0; d < ND; d++) begin
         mask = (64'd1 << ow_of(d)) - 64'd1;
         chk("in_ready", 64'(o_irdy[d]), 64'(!o_ovld[d] || out_rdy));
         if (!rst) begin
            if (hold[d]) begin
               chk("hold_vld", 64'(o_ovld[d]), 64'd1);
               chk("hold_sum", o_sum[d], h_sum[d]);
               chk("hold_car", o_car[d], h_car[d]);
            end
            if (o_ovld[d] && out_rdy) begin
               if (sb_val[d].size() == 0) begin
                  chk("spurious_out", 64'd1, 64'd0);
               end else begin
                  ev = sb_val[d].pop_front();
                  ec = sb_cyc[d].pop_front();
                  chk("sum_invariant", (o_sum[d] + o_car[d]) & mask, ev);
`ifdef CSA_FINAL_ADD_EN
                  chk("result", o_res[d], ev);
`endif
                  if (lat_chk) chk("latency", 64'(cyc - ec), 64'(lat_of(d)));
               end
               if (d == 1) begin
                  emits6.push_back((o_sum[d] + o_car[d]) & mask);
                  emit_cyc6.push_back(cyc);
               end
            end
            if (o_irdy[d] && in_vld) begin
               sb_val[d].push_back(exp_sum(d));
               sb_cyc[d].push_back(cyc);
            end
         end
         hold[d]  = !rst && o_ovld[d] && !out_rdy;
         h_sum[d] = o_sum[d];
         h_car[d] = o_car[d];
      end
      @(posedge clk);
      #1;
      if (rst) begin
         for (int d = 0; d < ND; d++) begin
            sb_val[d].delete();
            sb_cyc[d].delete();
         end
      end
      cyc = cyc + 1;
   endtask

   task automatic idle(input int n);
      in_vld = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int n_acc;
      checks = 0; failures = 0; cyc = 0; lat_chk = 1'b0;
      for (int d = 0; d < ND; d++) hold[d] = 1'b0;
      for (int k = 0; k < 16; k++) ops[k] = '0;
      rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
      cycle(); cycle();
      rst = 1'b0;
      cycle();
      chk("rst_in_ready", 64'(o_irdy[1]), 64'd1);
      chk("rst_out_valid", 64'(o_ovld[1]), 64'd0);
      chk("rst_sum", o_sum[1], 64'd0);
      chk("rst_carry", o_car[1], 64'd0);

      // All-ones bundle: 6 * 255 = 1530, fixed latency.
      lat_chk = 1'b1;
      emits6.delete(); emit_cyc6.delete();
      for (int k = 0; k < 16; k++) ops[k] = 8'hFF;
      in_vld = 1'b1; t0 = cyc;
      cycle();
      in_vld = 1'b0;
      for (int i = 0; i < 15 && emits6.size() == 0; i++) cycle();
      chk("t1_seen", 64'(emits6.size()), 64'd1);
      if (emits6.size() > 0) begin
         chk("t1_latency", 64'(emit_cyc6[0] - t0), 64'(lat_of(1)));
         chk("t1_sum", emits6[0], 64'd1530);
      end
      idle(10);

      // Back-to-back {1,0,..} then all-zero bundles.
      emits6.delete(); emit_cyc6.delete();
      for (int k = 0; k < 16; k++) ops[k] = '0;
      ops[0] = 8'd1; in_vld = 1'b1;
      cycle();
      ops[0] = 8'd0;
      cycle();
      idle(12);
      chk("t2_count", 64'(emits6.size()), 64'd2);
      if (emits6.size() >= 2) begin
         chk("t2_first", emits6[0], 64'd1);
         chk("t2_second", emits6[1], 64'd0);
         chk("t2_gap", 64'(emit_cyc6[1] - emit_cyc6[0]), 64'd1);
      end

      // Ten bundles with out_ready low on relative cycles 4..8.
      lat_chk = 1'b0;
      emits6.delete(); emit_cyc6.delete();
      n_acc = 0;
      for (int i = 0; i < 30; i++) begin
         out_rdy = !(i >= 4 && i <= 8);
         in_vld  = (n_acc < 10);
         rand_ops();
         cycle();
         chk("t3_in_ready", 64'(o_irdy[1]), 64'(!(i >= 4 && i <= 8)));
         if (o_irdy[1] && in_vld) n_acc = n_acc + 1;
      end
      out_rdy = 1'b1;
      idle(10);
      chk("t3_emitted", 64'(emits6.size()), 64'd10);

      // Reset with three bundles in flight.
      for (int i = 0; i < 3; i++) begin
         in_vld = 1'b1; rand_ops();
         cycle();
      end
      in_vld = 1'b0; rst = 1'b1;
      cycle();
      chk("t4_in_ready_rst", 64'(o_irdy[1]), 64'd1);
      rst = 1'b0;
      cycle();
      chk("t4_out_valid", 64'(o_ovld[1]), 64'd0);
      chk("t4_sum", o_sum[1], 64'd0);
      chk("t4_carry", o_car[1], 64'd0);
`ifdef CSA_FINAL_ADD_EN
      chk("t4_result", o_res[1], 64'd0);
`endif
      emits6.delete(); emit_cyc6.delete();
      idle(15);
      chk("t4_stale", 64'(emits6.size()), 64'd0);

      // 1000 random bundles at full drain rate with latency checking.
      lat_chk = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 3000 && n_acc < 1000; i++) begin
         in_vld = ($urandom_range(0, 9) < 8);
         rand_ops();
         cycle();
         if (o_irdy[1] && in_vld) n_acc = n_acc + 1;
      end
      chk("t5_accepted", 64'(n_acc), 64'd1000);
      idle(10);

      // Random valid and random backpressure.
      lat_chk = 1'b0;
      for (int i = 0; i < 400; i++) begin
         in_vld  = ($urandom_range(0, 9) < 7);
         out_rdy = ($urandom_range(0, 9) < 6);
         rand_ops();
         cycle();
      end
      out_rdy = 1'b1;
      idle(20);
      for (int d = 0; d < ND; d++) chk("drained", 64'(sb_val[d].size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
